// File: rtl/reaction_pkg.sv
// Shared state encoding, ms-value sizing and LFSR constants for the reaction-time trial logic.
// Pure definitions: no latency, no flow control.
package reaction_pkg;

    localparam int          MS_W      = 14;
    localparam int          MAX_MS    = 9999;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_GO    = 3'd2,
        ST_DONE  = 3'd3,
        ST_FALSE = 3'd4
    } state_t;

    // Right-shifting Galois step; a non-zero seed never reaches all-zero.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Prescaler emitting a 1-cycle tick every TICK_DIV cycles; i_clr restarts the period.
// Tick is combinational from the count, first tick TICK_DIV cycles after a clear; no backpressure.
module ms_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(TICK_DIV - 1));
    assign o_tick = w_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/reaction_controller.sv
// Reaction-time trial sequencer: random foreperiod, GO light, ms counting until react press.
// Button events land 3 cycles after the raw input rises; all outputs registered; no backpressure.
module reaction_controller #(
    parameter int TICK_DIV     = 50000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11,
    parameter int MAX_MS       = reaction_pkg::MAX_MS,
    parameter int MS_W         = reaction_pkg::MS_W
) (
    input  logic            clk50M,
    input  logic            reset_n,
    input  logic            start_btn,
    input  logic            react_btn,
    output logic            go_led,
    output logic            busy,
    output logic [MS_W-1:0] result_ms,
    output logic            result_valid,
    output logic            timeout,
    output logic            false_start,
    output logic [MS_W-1:0] best_ms,
    output logic [2:0]      state_dbg
);

    import reaction_pkg::*;

    if (MIN_DELAY_MS + (2 ** RAND_BITS) - 1 > (2 ** MS_W) - 1) begin : g_delay_range_chk
        $error("MIN_DELAY_MS + 2**RAND_BITS - 1 does not fit in MS_W bits");
    end

    state_t          r_state, w_next;
    logic [1:0]      r_start_sync, r_react_sync;
    logic            r_start_d, r_react_d, r_start_ev, r_react_ev;
    logic [15:0]     r_lfsr;
    logic [MS_W-1:0] r_delay, r_ms, r_result, r_best;
    logic            r_valid, r_timeout, r_false, r_go_led, r_busy;
    logic            w_tick, w_tick_clr, w_go_led_nxt, w_busy_nxt;

    // Raw buttons are asynchronous: 2-FF sync, then a registered rising-edge event.
    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            r_start_sync <= '0;
            r_react_sync <= '0;
            r_start_d    <= 1'b0;
            r_react_d    <= 1'b0;
            r_start_ev   <= 1'b0;
            r_react_ev   <= 1'b0;
            r_lfsr       <= LFSR_SEED;
        end else begin
            r_start_sync <= {r_start_sync[0], start_btn};
            r_react_sync <= {r_react_sync[0], react_btn};
            r_start_d    <= r_start_sync[1];
            r_react_d    <= r_react_sync[1];
            r_start_ev   <= r_start_sync[1] & ~r_start_d;
            r_react_ev   <= r_react_sync[1] & ~r_react_d;
            r_lfsr       <= lfsr_next(r_lfsr);
        end
    end

    assign w_tick_clr = (w_next != r_state) && ((w_next == ST_ARMED) || (w_next == ST_GO));

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .i_clk   (clk50M),
        .i_rst_n (reset_n),
        .i_clr   (w_tick_clr),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_go_led <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_go_led <= w_go_led_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    // A react press always beats a same-cycle tick, in ARMED and in GO.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_FALSE: if (r_start_ev) w_next = ST_ARMED;
            ST_ARMED: begin
                if (r_react_ev)                             w_next = ST_FALSE;
                else if (w_tick && (r_delay == MS_W'(1)))   w_next = ST_GO;
            end
            ST_GO: begin
                if (r_react_ev)                                 w_next = ST_DONE;
                else if (w_tick && (r_ms == MS_W'(MAX_MS - 1))) w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_go_led_nxt = (w_next == ST_GO);
        w_busy_nxt   = (w_next == ST_ARMED) || (w_next == ST_GO);
    end

    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            r_delay   <= '0;
            r_ms      <= '0;
            r_result  <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_false   <= 1'b0;
            r_best    <= MS_W'(MAX_MS);
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_FALSE: begin
                    if (r_start_ev) begin
                        r_delay   <= MS_W'(MIN_DELAY_MS) + MS_W'(r_lfsr[RAND_BITS-1:0]);
                        r_valid   <= 1'b0;
                        r_timeout <= 1'b0;
                        r_false   <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (r_react_ev) begin
                        r_false <= 1'b1;
                    end else if (w_tick) begin
                        r_delay <= r_delay - MS_W'(1);
                        if (r_delay == MS_W'(1)) r_ms <= '0;
                    end
                end
                ST_GO: begin
                    if (r_react_ev) begin
                        r_result <= r_ms;
                        r_valid  <= 1'b1;
                        if (r_ms < r_best) r_best <= r_ms;
                    end else if (w_tick) begin
                        if (r_ms == MS_W'(MAX_MS - 1)) begin
                            r_ms      <= MS_W'(MAX_MS);
                            r_result  <= MS_W'(MAX_MS);
                            r_valid   <= 1'b1;
                            r_timeout <= 1'b1;
                        end else if (r_ms != MS_W'(MAX_MS)) begin
                            r_ms <= r_ms + MS_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign go_led       = r_go_led;
    assign busy         = r_busy;
    assign result_ms    = r_result;
    assign result_valid = r_valid;
    assign timeout      = r_timeout;
    assign false_start  = r_false;
    assign best_ms      = r_best;
    assign state_dbg    = r_state;

endmodule

// File: tb/tb_reaction_controller.sv
// Directed bench for reaction_controller with small timing parameters (4-cycle ms, 20 ms cap).
module tb_reaction_controller;

    localparam int TD    = 4;
    localparam int MIN_D = 3;
    localparam int RB    = 2;
    localparam int MAXM  = 20;
    localparam int MSW   = 14;

    localparam int S_IDLE  = 0;
    localparam int S_ARMED = 1;
    localparam int S_GO    = 2;
    localparam int S_DONE  = 3;
    localparam int S_FALSE = 4;

    logic           clk50M    = 1'b0;
    logic           reset_n   = 1'b0;
    logic           start_btn = 1'b0;
    logic           react_btn = 1'b0;
    logic           go_led, busy, result_valid, timeout, false_start;
    logic [MSW-1:0] result_ms, best_ms;
    logic [2:0]     state_dbg;

    int n_chk = 0;
    int n_bad = 0;

    logic [15:0] m_lfsr, m_prev;

    always #10 clk50M = ~clk50M;

    reaction_controller #(
        .TICK_DIV     (TD),
        .MIN_DELAY_MS (MIN_D),
        .RAND_BITS    (RB),
        .MAX_MS       (MAXM),
        .MS_W         (MSW)
    ) dut (
        .clk50M       (clk50M),
        .reset_n      (reset_n),
        .start_btn    (start_btn),
        .react_btn    (react_btn),
        .go_led       (go_led),
        .busy         (busy),
        .result_ms    (result_ms),
        .result_valid (result_valid),
        .timeout      (timeout),
        .false_start  (false_start),
        .best_ms      (best_ms),
        .state_dbg    (state_dbg)
    );

    // Reference 16-bit Galois LFSR (mask B400); m_prev is the value seen during the previous cycle.
    always @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    task automatic chk_val(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input int st, input int budget, output int cyc);
        cyc = 0;
        while (int'(state_dbg) != st && cyc < budget) begin
            @(negedge clk50M);
            cyc++;
        end
        if (int'(state_dbg) != st) chk_val("wait_state_timeout", int'(state_dbg), st);
    endtask

    task automatic settle();
        repeat (6) @(negedge clk50M);
    endtask

    task automatic do_start(output int exp_d);
        int c;
        start_btn = 1'b1;
        wait_state(S_ARMED, 10, c);
        chk_val("start_latency", c, 4);
        start_btn = 1'b0;
        exp_d = TD * (MIN_D + int'(m_prev[RB-1:0]));
        chk_val("armed_busy", int'(busy), 1);
        chk_val("armed_go_led", int'(go_led), 0);
        chk_val("armed_valid_clr", int'(result_valid), 0);
    endtask

    task automatic react_trial(input int p, input int exp_res, input int exp_best, input bit start_in_go);
        int d, c, rem;
        do_start(d);
        wait_state(S_GO, 40, c);
        chk_val("go_delay", c, d);
        chk_val("go_led_on", int'(go_led), 1);
        rem = p;
        if (start_in_go) begin
            start_btn = 1'b1;
            repeat (8) @(negedge clk50M);
            start_btn = 1'b0;
            chk_val("start_in_go_ignored", int'(state_dbg), S_GO);
            rem = p - 8;
        end
        repeat (rem) @(negedge clk50M);
        react_btn = 1'b1;
        wait_state(S_DONE, 10, c);
        chk_val("react_latency", c, 4);
        react_btn = 1'b0;
        chk_val("result_ms", int'(result_ms), exp_res);
        chk_val("result_valid", int'(result_valid), 1);
        chk_val("timeout_clr", int'(timeout), 0);
        chk_val("false_start_clr", int'(false_start), 0);
        chk_val("best_ms", int'(best_ms), exp_best);
        chk_val("done_go_led", int'(go_led), 0);
        chk_val("done_busy", int'(busy), 0);
        settle();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_val({tag, "_state"}, int'(state_dbg), S_IDLE);
        chk_val({tag, "_go_led"}, int'(go_led), 0);
        chk_val({tag, "_busy"}, int'(busy), 0);
        chk_val({tag, "_result"}, int'(result_ms), 0);
        chk_val({tag, "_valid"}, int'(result_valid), 0);
        chk_val({tag, "_timeout"}, int'(timeout), 0);
        chk_val({tag, "_false"}, int'(false_start), 0);
        chk_val({tag, "_best"}, int'(best_ms), MAXM);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, c;

        repeat (2) @(negedge clk50M);
        chk_reset_vals("rst");
        reset_n = 1'b1;
        settle();

        // Timeout: no press, 20 ms cap reached after 80 cycles of GO.
        do_start(d);
        wait_state(S_GO, 40, c);
        chk_val("to_go_delay", c, d);
        wait_state(S_DONE, 100, c);
        chk_val("to_cycles", c, MAXM * TD);
        chk_val("to_result", int'(result_ms), MAXM);
        chk_val("to_flag", int'(timeout), 1);
        chk_val("to_valid", int'(result_valid), 1);
        chk_val("to_best_kept", int'(best_ms), MAXM);
        chk_val("to_go_led", int'(go_led), 0);
        settle();

        // Best tracking: 9, 5, 12 (start ignored during the last GO).
        react_trial(34, 9, 9, 1'b0);
        react_trial(18, 5, 5, 1'b0);
        react_trial(46, 12, 5, 1'b1);

        // React coincident with the GO tick that would take ms_cnt from 7 to 8.
        react_trial(28, 7, 5, 1'b0);

        // False start with start held throughout: one start event only.
        start_btn = 1'b1;
        wait_state(S_ARMED, 10, c);
        chk_val("fs_start_latency", c, 4);
        react_btn = 1'b1;
        wait_state(S_FALSE, 10, c);
        chk_val("fs_latency", c, 4);
        chk_val("fs_flag", int'(false_start), 1);
        chk_val("fs_go_led", int'(go_led), 0);
        chk_val("fs_valid", int'(result_valid), 0);
        chk_val("fs_best", int'(best_ms), 5);
        repeat (20) @(negedge clk50M);
        chk_val("held_start_single", int'(state_dbg), S_FALSE);
        start_btn = 1'b0;
        react_btn = 1'b0;
        settle();

        // React lands on the same edge as the expiring foreperiod tick.
        do_start(d);
        repeat (d - 4) @(negedge clk50M);
        react_btn = 1'b1;
        wait_state(S_FALSE, 10, c);
        chk_val("race_latency", c, 4);
        chk_val("race_false", int'(false_start), 1);
        chk_val("race_go_led", int'(go_led), 0);
        chk_val("race_valid", int'(result_valid), 0);
        react_btn = 1'b0;
        settle();

        // Asynchronous reset in the middle of GO.
        do_start(d);
        wait_state(S_GO, 40, c);
        chk_val("pre_rst_go", int'(go_led), 1);
        @(posedge clk50M);
        #3 reset_n = 1'b0;
        #1 chk_reset_vals("midrst");
        @(negedge clk50M);
        @(negedge clk50M);
        reset_n = 1'b1;
        settle();

        react_trial(22, 6, 6, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
